// File: rtl/floo_vc_injector_pkg.sv
// Shared helpers for the VC injector: VC index sizing and round-robin stepping.
package floo_vc_injector_pkg;

  function automatic int unsigned vcIdxWidth(input int unsigned numVc);
    return (numVc > 1) ? $clog2(numVc) : 1;
  endfunction

  function automatic int unsigned rrNext(input int unsigned last,
                                         input int unsigned offset,
                                         input int unsigned numVc);
    return (last + offset) % numVc;
  endfunction

endpackage

// File: rtl/floo_vc_injector_if.sv
// Tile-side per-VC handshake plus the single physical channel into the mesh local port.
interface floo_vc_injector_if #(
  parameter int unsigned NumVirtChannels = 2,
  parameter type         flit_t          = logic
);
  logic  [NumVirtChannels-1:0] valid_i;
  logic  [NumVirtChannels-1:0] ready_o;
  flit_t [NumVirtChannels-1:0] data_i;
  logic  [NumVirtChannels-1:0] valid_o;
  logic  [NumVirtChannels-1:0] ready_i;
  flit_t                       data_o;
  logic  [NumVirtChannels-1:0] empty_o;

  modport slave (
    input  valid_i, data_i, ready_i,
    output ready_o, valid_o, data_o, empty_o
  );

  modport master (
    output valid_i, data_i, ready_i,
    input  ready_o, valid_o, data_o, empty_o
  );
endinterface

// File: rtl/floo_vc_injector_fifo.sv
// Registered-output (non fall-through) circular FIFO, one instance per virtual channel.
module floo_vc_injector_fifo #(
  parameter int unsigned Depth = 2,
  parameter type         dtype = logic
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic push_i,
  input  dtype data_i,
  input  logic pop_i,
  output dtype data_o,
  output logic full_o,
  output logic empty_o
);
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  dtype            mem_q [Depth];
  logic [PtrW-1:0] rdPtr_q, rdPtr_d;
  logic [PtrW-1:0] wrPtr_q, wrPtr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            doPush, doPop;

  function automatic logic [PtrW-1:0] incPtr(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign doPush  = push_i & ~full_o;
  assign doPop   = pop_i & ~empty_o;
  assign data_o  = mem_q[rdPtr_q];

  always_comb begin
    rdPtr_d = rdPtr_q;
    wrPtr_d = wrPtr_q;
    count_d = count_q;
    if (doPush) wrPtr_d = incPtr(wrPtr_q);
    if (doPop)  rdPtr_d = incPtr(rdPtr_q);
    case ({doPush, doPop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else begin
      rdPtr_q <= rdPtr_d;
      wrPtr_q <= wrPtr_d;
      count_q <= count_d;
      if (doPush) mem_q[wrPtr_q] <= data_i;
    end
  end

endmodule

// File: rtl/floo_vc_injector.sv
// Multiplexes per-VC tile flits onto one physical mesh channel through per-VC FIFOs,
// a round-robin picker and a single output register that never retracts or switches VC.
module floo_vc_injector
  import floo_vc_injector_pkg::*;
#(
  parameter int unsigned NumVirtChannels = 2,
  parameter int unsigned FifoDepth       = 2,
  parameter type         flit_t          = logic
) (
  input logic                 clk_i,
  input logic                 rst_ni,
  floo_vc_injector_if.slave   inj
);
  localparam int unsigned VcIdxW = vcIdxWidth(NumVirtChannels);

  logic [NumVirtChannels-1:0] full, empty, push, pop;
  flit_t                      fifoData [NumVirtChannels];

  logic              outValid_q, outValid_d;
  logic [VcIdxW-1:0] outVc_q, outVc_d;
  flit_t             outData_q, outData_d;
  logic [VcIdxW-1:0] rrPtr_q, rrPtr_d;

  logic              selFound, transfer, load;
  logic [VcIdxW-1:0] selVc;
  logic [NumVirtChannels-1:0] validVec;

  assign push        = inj.valid_i & ~full;
  assign inj.ready_o = ~full;
  assign inj.empty_o = empty;

  for (genvar v = 0; v < NumVirtChannels; v++) begin : gen_vc_fifo
    floo_vc_injector_fifo #(
      .Depth (FifoDepth),
      .dtype (flit_t)
    ) i_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (push[v]),
      .data_i  (inj.data_i[v]),
      .pop_i   (pop[v]),
      .data_o  (fifoData[v]),
      .full_o  (full[v]),
      .empty_o (empty[v])
    );
  end

  // Search starts one past the last loaded VC so every VC gets its turn.
  always_comb begin
    logic [VcIdxW-1:0] cand;
    selVc    = '0;
    selFound = 1'b0;
    cand     = '0;
    for (int unsigned k = 1; k <= NumVirtChannels; k++) begin
      cand = VcIdxW'(rrNext(32'(rrPtr_q), k, NumVirtChannels));
      if (!selFound && !empty[cand]) begin
        selFound = 1'b1;
        selVc    = cand;
      end
    end
  end

  assign transfer = outValid_q & inj.ready_i[outVc_q];
  assign load     = (~outValid_q | transfer) & selFound;

  always_comb begin
    pop        = '0;
    outValid_d = outValid_q;
    outVc_d    = outVc_q;
    outData_d  = outData_q;
    rrPtr_d    = rrPtr_q;
    if (load) begin
      pop[selVc] = 1'b1;
      outValid_d = 1'b1;
      outVc_d    = selVc;
      outData_d  = fifoData[selVc];
      rrPtr_d    = selVc;
    end else if (transfer) begin
      outValid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      outValid_q <= 1'b0;
      outVc_q    <= '0;
      outData_q  <= '0;
      rrPtr_q    <= VcIdxW'(NumVirtChannels - 1);
    end else begin
      outValid_q <= outValid_d;
      outVc_q    <= outVc_d;
      outData_q  <= outData_d;
      rrPtr_q    <= rrPtr_d;
    end
  end

  always_comb begin
    validVec = '0;
    if (outValid_q) validVec[outVc_q] = 1'b1;
  end

  assign inj.valid_o = validVec;
  assign inj.data_o  = outData_q;

endmodule
